// File: rtl/tri_raster_scanner.sv
// ---------------------------------------------------------------------------
// tri_raster_scanner
//   Sequential front end for a combinational barycentric evaluator. Accepts
//   one triangle (three signed fixed-point vertices) per handshake, derives
//   its integer bounding box clamped to the evaluable grid [0, L], walks the
//   box in raster order driving bc_eval_x/y, and streams every covered pixel
//   downstream over a valid/ready handshake.
//
//   L = 2^min(INT_BITS, EVAL_BITS) - 1
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   tri_valid/ready     triangle handshake; ready only while IDLE
//   x0..y2              vertices, signed, DEC_BITS fractional bits
//   bc_eval_x/y         registered point presented to the evaluator
//   bc_in_tris          evaluator result for bc_eval_x/y (same cycle)
//   pix_valid/ready     covered-pixel handshake, pix_x/pix_y payload
//   busy                accept .. last cycle before done
//   done                one-cycle pulse when a triangle completes
//   pix_count           (PIX_COUNT_EN only) pixels handed off this triangle
//
// Build option
//   PIX_COUNT_EN        adds the pix_count output and its counter
// ---------------------------------------------------------------------------
module tri_raster_scanner #(
  parameter int unsigned EVAL_BITS = 8,
  parameter int unsigned INT_BITS  = 4,
  parameter int unsigned DEC_BITS  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tri_valid,
  output logic                             tri_ready,
  input  logic signed [INT_BITS+DEC_BITS:0] x0,
  input  logic signed [INT_BITS+DEC_BITS:0] y0,
  input  logic signed [INT_BITS+DEC_BITS:0] x1,
  input  logic signed [INT_BITS+DEC_BITS:0] y1,
  input  logic signed [INT_BITS+DEC_BITS:0] x2,
  input  logic signed [INT_BITS+DEC_BITS:0] y2,
  output logic [EVAL_BITS-1:0]             bc_eval_x,
  output logic [EVAL_BITS-1:0]             bc_eval_y,
  input  logic                             bc_in_tris,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [EVAL_BITS-1:0]             pix_x,
  output logic [EVAL_BITS-1:0]             pix_y,
  output logic                             busy,
  output logic                             done
`ifdef PIX_COUNT_EN
  ,
  output logic [2*EVAL_BITS-1:0]           pix_count
`endif
);

  localparam int unsigned VW   = INT_BITS + DEC_BITS + 1;
  localparam int unsigned LB   = (INT_BITS < EVAL_BITS) ? INT_BITS : EVAL_BITS;
  // Signed compare width wide enough for both the vertex integer part and L.
  localparam int unsigned CMPW = ((INT_BITS > EVAL_BITS) ? INT_BITS + 1 : EVAL_BITS + 1) + 1;
  localparam logic signed [CMPW-1:0] LIM = CMPW'((1 << LB) - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Floor of a fixed-point value (arithmetic shift), sign-extended to CMPW.
  function automatic logic signed [CMPW-1:0] floor_int(input logic signed [VW-1:0] v);
    logic signed [VW-1:0] s;
    s = v >>> DEC_BITS;
    return CMPW'(s);
  endfunction

  function automatic logic signed [CMPW-1:0] min3(input logic signed [CMPW-1:0] a,
                                                  input logic signed [CMPW-1:0] b,
                                                  input logic signed [CMPW-1:0] c);
    logic signed [CMPW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [CMPW-1:0] max3(input logic signed [CMPW-1:0] a,
                                                  input logic signed [CMPW-1:0] b,
                                                  input logic signed [CMPW-1:0] c);
    logic signed [CMPW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Clamp a signed integer coordinate into [0, L].
  function automatic logic [EVAL_BITS-1:0] clamp(input logic signed [CMPW-1:0] v);
    logic [EVAL_BITS-1:0] r;
    if (v[CMPW-1]) begin
      r = '0;
    end else if (v > LIM) begin
      r = EVAL_BITS'(LIM);
    end else begin
      r = EVAL_BITS'(v);
    end
    return r;
  endfunction

  logic [2:0]           state_q, state_d;
  logic signed [VW-1:0] vx0_q, vx0_d, vy0_q, vy0_d;
  logic signed [VW-1:0] vx1_q, vx1_d, vy1_q, vy1_d;
  logic signed [VW-1:0] vx2_q, vx2_d, vy2_q, vy2_d;
  logic [EVAL_BITS-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [EVAL_BITS-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [EVAL_BITS-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [EVAL_BITS-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic                 pix_valid_q, pix_valid_d;
  logic                 tri_ready_q, tri_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef PIX_COUNT_EN
  logic [2*EVAL_BITS-1:0] cnt_q, cnt_d;
`endif

  logic signed [CMPW-1:0] fxmin, fxmax, fymin, fymax;
  logic                   box_empty;
  logic                   accept;
  logic                   pix_fire;
  logic                   stall;

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    vx0_d       = vx0_q;
    vy0_d       = vy0_q;
    vx1_d       = vx1_q;
    vy1_d       = vy1_q;
    vx2_d       = vx2_q;
    vy2_d       = vy2_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_valid_d = pix_valid_q;
`ifdef PIX_COUNT_EN
    cnt_d       = cnt_q;
`endif

    fxmin = min3(floor_int(vx0_q), floor_int(vx1_q), floor_int(vx2_q));
    fxmax = max3(floor_int(vx0_q), floor_int(vx1_q), floor_int(vx2_q));
    fymin = min3(floor_int(vy0_q), floor_int(vy1_q), floor_int(vy2_q));
    fymax = max3(floor_int(vy0_q), floor_int(vy1_q), floor_int(vy2_q));
    // Box lies entirely off-grid in at least one axis.
    box_empty = fxmax[CMPW-1] | fymax[CMPW-1] | (fxmin > LIM) | (fymin > LIM);

    accept   = tri_valid & tri_ready_q;
    pix_fire = pix_valid_q & pix_ready;
    // Covered point but the output register is still occupied.
    stall    = bc_in_tris & pix_valid_q & ~pix_ready;

    if (pix_fire) begin
      pix_valid_d = 1'b0;
`ifdef PIX_COUNT_EN
      cnt_d = cnt_q + 1'b1;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          vx0_d   = x0;
          vy0_d   = y0;
          vx1_d   = x1;
          vy1_d   = y1;
          vx2_d   = x2;
          vy2_d   = y2;
          state_d = ST_SETUP;
`ifdef PIX_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_SETUP: begin
        xmin_d = clamp(fxmin);
        xmax_d = clamp(fxmax);
        ymin_d = clamp(fymin);
        ymax_d = clamp(fymax);
        if (box_empty) begin
          state_d = ST_DONE;
        end else begin
          cx_d    = clamp(fxmin);
          cy_d    = clamp(fymin);
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (!stall) begin
          if (bc_in_tris) begin
            pix_x_d     = cx_q;
            pix_y_d     = cy_q;
            pix_valid_d = 1'b1;
          end
          // Raster advance; the last box point hands over to DRAIN.
          if (cx_q == xmax_q) begin
            if (cy_q == ymax_q) begin
              state_d = ST_DRAIN;
            end else begin
              cx_d = xmin_q;
              cy_d = cy_q + 1'b1;
            end
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        // Leave as soon as the output slot will be empty next cycle.
        if (!pix_valid_q || pix_ready) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tri_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_SETUP) || (state_d == ST_SCAN) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vx0_q       <= '0;
      vy0_q       <= '0;
      vx1_q       <= '0;
      vy1_q       <= '0;
      vx2_q       <= '0;
      vy2_q       <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
      tri_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PIX_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vx0_q       <= vx0_d;
      vy0_q       <= vy0_d;
      vx1_q       <= vx1_d;
      vy1_q       <= vy1_d;
      vx2_q       <= vx2_d;
      vy2_q       <= vy2_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_valid_q <= pix_valid_d;
      tri_ready_q <= tri_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef PIX_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign tri_ready = tri_ready_q;
  assign bc_eval_x = cx_q;
  assign bc_eval_y = cy_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef PIX_COUNT_EN
  assign pix_count = cnt_q;
`endif

endmodule

// File: tb/tb_tri_raster_scanner.sv
// Directed bench for tri_raster_scanner: a stub evaluator answers bc_in_tris
// from bc_eval_x according to a per-test mode, and every pixel handed off is
// compared with a raster walk of a hand-computed bounding box.
module tb_tri_raster_scanner;

  logic               clk;
  logic               rst_n;
  logic               tri_valid;
  logic               tri_ready;
  logic signed [12:0] x0, y0, x1, y1, x2, y2;
  logic [7:0]         bc_eval_x, bc_eval_y;
  logic               bc_in_tris;
  logic               pix_valid;
  logic               pix_ready;
  logic [7:0]         pix_x, pix_y;
  logic               busy;
  logic               done;
`ifdef PIX_COUNT_EN
  logic [15:0]        pix_count;
`endif

  int mode;   // 0: all covered, 1: none covered, 2: covered when x even
  int n_pass;
  int n_chk;

  tri_raster_scanner #(.EVAL_BITS(8), .INT_BITS(4), .DEC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .bc_eval_x(bc_eval_x), .bc_eval_y(bc_eval_y), .bc_in_tris(bc_in_tris),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .done(done)
`ifdef PIX_COUNT_EN
    , .pix_count(pix_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit covered(input int m, input int x);
    if (m == 0) return 1'b1;
    if (m == 1) return 1'b0;
    return (x % 2) == 0;
  endfunction

  always_comb bc_in_tris = covered(mode, int'(bc_eval_x));

  typedef struct {
    logic [12:0] x0, y0, x1, y1, x2, y2;
    int mode;
    int stall_k, stall_len;        // cycle (after accept) and length of pix_ready=0
    int spx, spy, sex, sey;        // expected held pixel / eval point while stalled
    int bx0, bx1, by0, by1;        // hand-computed clamped box
    int exp_n;                     // expected pixel count
    int exp_lat;                   // cycles from accept to done
  } vec_t;

  vec_t tv[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tri_ready"}, int'(tri_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_eval_x"}, int'(bc_eval_x), 0);
    chk({tag, "_eval_y"}, int'(bc_eval_y), 0);
  endtask

  task automatic run_row(input int id, input vec_t v);
    int  ex[$];
    int  ey[$];
    int  got;
    bit  fin;
    string tag;
    tag = $sformatf("row%0d", id);
    for (int y = v.by0; y <= v.by1; y++)
      for (int x = v.bx0; x <= v.bx1; x++)
        if (covered(v.mode, x)) begin
          ex.push_back(x);
          ey.push_back(y);
        end
    mode = v.mode;
    pix_ready = 1'b1;
    x0 = v.x0; y0 = v.y0; x1 = v.x1; y1 = v.y1; x2 = v.x2; y2 = v.y2;
    tri_valid = 1'b1;
    chk({tag, "_tri_ready"}, int'(tri_ready), 1);
    tick();
    tri_valid = 1'b0;
    got = 0;
    fin = 1'b0;
    for (int k = 1; k <= 300 && !fin; k++) begin
      pix_ready = !(v.stall_k > 0 && k >= v.stall_k && k < v.stall_k + v.stall_len);
      if (k == 1) chk({tag, "_busy"}, int'(busy), 1);
      if (k == 2 && v.exp_lat > 2) begin
        chk({tag, "_first_eval_x"}, int'(bc_eval_x), v.bx0);
        chk({tag, "_first_eval_y"}, int'(bc_eval_y), v.by0);
      end
      if (!pix_ready) begin
        chk({tag, "_stall_valid"}, int'(pix_valid), 1);
        chk({tag, "_stall_pix_x"}, int'(pix_x), v.spx);
        chk({tag, "_stall_pix_y"}, int'(pix_y), v.spy);
        chk({tag, "_stall_eval_x"}, int'(bc_eval_x), v.sex);
        chk({tag, "_stall_eval_y"}, int'(bc_eval_y), v.sey);
      end
      if (pix_valid && pix_ready) begin
        chk({tag, "_pix_in_range"}, int'(got < ex.size()), 1);
        if (got < ex.size()) begin
          chk($sformatf("%s_pix%0d_x", tag, got), int'(pix_x), ex[got]);
          chk($sformatf("%s_pix%0d_y", tag, got), int'(pix_y), ey[got]);
        end
        got++;
      end
      if (done) begin
        chk({tag, "_done_latency"}, k, v.exp_lat);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        chk({tag, "_valid_at_done"}, int'(pix_valid), 0);
        fin = 1'b1;
      end else begin
        tick();
      end
    end
    if (!fin) chk({tag, "_done_timeout"}, 0, 1);
    chk({tag, "_pix_total"}, got, v.exp_n);
`ifdef PIX_COUNT_EN
    chk({tag, "_pix_count"}, int'(pix_count), v.exp_n);
`endif
    pix_ready = 1'b1;
    tick();
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_ready_after"}, int'(tri_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_pass = 0;
    n_chk  = 0;
    mode   = 0;

    //          x0       y0       x1       y1       x2       y2      md sk sl spx spy sex sey bx0 bx1 by0 by1  n lat
    tv[0] = '{13'h0100, 13'h0100, 13'h0300, 13'h0100, 13'h0100, 13'h0300, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 3, 9, 12};
    tv[1] = '{13'h0100, 13'h0100, 13'h0300, 13'h0100, 13'h0100, 13'h0300, 0, 4, 5, 2, 1, 3, 1, 1, 3, 1, 3, 9, 17};
    tv[2] = '{13'h1D80, 13'h0200, 13'h0FFF, 13'h0200, 13'h0500, 13'h0200, 2, 0, 0, 0, 0, 0, 0, 0, 15, 2, 2, 8, 19};
    tv[3] = '{13'h1F00, 13'h0100, 13'h1F00, 13'h0100, 13'h1F00, 13'h0100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
    tv[4] = '{13'h0280, 13'h0340, 13'h0200, 13'h0300, 13'h02FF, 13'h03C0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 3, 3, 1, 4};
    tv[5] = '{13'h0080, 13'h1F00, 13'h0200, 13'h0400, 13'h0100, 13'h0200, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 4, 0, 18};

    rst_n = 1'b0;
    tri_valid = 1'b0;
    pix_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    tick();
    tick();
    chk_idle_outputs("por");
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("idle_reset");
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_row(i, tv[i]);

    // Abort in the middle of a scan at point (2,2).
    mode = 0;
    pix_ready = 1'b1;
    x0 = tv[0].x0; y0 = tv[0].y0; x1 = tv[0].x1; y1 = tv[0].y1;
    x2 = tv[0].x2; y2 = tv[0].y2;
    tri_valid = 1'b1;
    tick();
    tri_valid = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      if (bc_eval_x == 8'd2 && bc_eval_y == 8'd2 && busy) found = 1'b1;
      else tick();
    end
    chk("abort_reached_2_2", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("abort_post_idle_done", int'(done), 0);
    run_row(6, tv[4]);
    run_row(7, tv[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
